// File: rtl/led_matrix_scan_pkg.sv
// Shared definitions for the action stage and the LED matrix row scanner:
// FSM state encoding, default grid size and a counter-width helper.
package led_matrix_scan_pkg;

    localparam int GS_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_BLANK = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_e;

    // Width of a counter that must hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_matrix_scan_timer.sv
// Dwell counter for the row scanner: clears on demand, counts while enabled
// and flags the terminal count (DWELL-1).
module scan_timer
    import led_matrix_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int            CW     = cnt_width(DWELL);
    localparam logic [CW-1:0] TC_VAL = CW'(DWELL - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins over increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexing scanner: snapshots a GS x GS frame on start and lights one
// row at a time for DWELL cycles. Define SCAN_BLANK_EN to insert a blank cycle between rows.
module led_matrix_scan
    import led_matrix_scan_pkg::*;
#(
    parameter int GS    = GS_DEFAULT,
    parameter int DWELL = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [GS*GS-1:0] matrix_i,
    input  logic            start_i,
    output logic [GS-1:0]   row_val_o,
    output logic [GS-1:0]   col_val_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int            RW       = cnt_width(GS);
    localparam logic [RW-1:0] LAST_ROW = RW'(GS - 1);

    scan_state_e      state_q,   state_d;
    logic [RW-1:0]    row_q,     row_d;
    logic [GS*GS-1:0] frame_q,   frame_d;
    logic [GS-1:0]    row_val_q, row_val_d;
    logic [GS-1:0]    col_val_q, col_val_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic             tc_s;
    logic [RW-1:0]    next_row_s;
    logic [GS-1:0]    rows_s [GS];

    function automatic logic [GS-1:0] row_onehot(input logic [RW-1:0] r);
        return GS'(1) << r;
    endfunction

    scan_timer #(
        .DWELL (DWELL)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   ((state_q != ST_SCAN) || tc_s),
        .en_i    (state_q == ST_SCAN),
        .tc_o    (tc_s)
    );

    assign next_row_s = row_q + RW'(1);

    // Split the captured frame into per-row column patterns.
    always_comb begin
        for (int r = 0; r < GS; r++) begin
            rows_s[r] = frame_q[r*GS +: GS];
        end
    end

    // State, row index and frame register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            frame_q   <= '0;
            row_val_q <= '0;
            col_val_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            frame_q   <= frame_d;
            row_val_q <= row_val_d;
            col_val_q <= col_val_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; the row index advances when the dwell expires.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        frame_d = frame_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SCAN;
                    row_d   = '0;
                    frame_d = matrix_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (tc_s) begin
                    if (row_q == LAST_ROW) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d = next_row_s;
`ifdef SCAN_BLANK_EN
                        state_d = ST_BLANK;
`else
                        state_d = ST_SCAN;
`endif
                    end
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_BLANK: begin
                state_d = ST_SCAN;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                row_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                row_d   = '0;
            end
        endcase
    end

    // Output logic: outputs are computed one cycle ahead so they come straight from flops.
    always_comb begin
        row_val_d = '0;
        col_val_d = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    row_val_d = GS'(1);
                    col_val_d = matrix_i[GS-1:0];
                    busy_d    = 1'b1;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            ST_SCAN: begin
                busy_d = 1'b1;
                if (tc_s) begin
                    if (row_q == LAST_ROW) begin
                        done_d = 1'b1;
                    end else begin
`ifdef SCAN_BLANK_EN
                        row_val_d = '0;
                        col_val_d = '0;
`else
                        row_val_d = row_onehot(next_row_s);
                        col_val_d = rows_s[next_row_s];
`endif
                    end
                end else begin
                    row_val_d = row_val_q;
                    col_val_d = col_val_q;
                end
            end
            ST_BLANK: begin
                // Row index was already advanced on entry to BLANK.
                row_val_d = row_onehot(row_q);
                col_val_d = rows_s[row_q];
                busy_d    = 1'b1;
            end
            ST_DONE: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign row_val_o = row_val_q;
    assign col_val_o = col_val_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule
